// File: rtl/div_unit.sv
// Iterative 32-bit RV32M divide unit (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Restoring division on magnitudes with a start/busy/done handshake for pipeline stalls.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           is_rem_q, is_rem_d;
    logic           neg_quo_q, neg_quo_d;
    logic           neg_rem_q, neg_rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   dvsr_q, dvsr_d;
    logic [W:0]     rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   result_q, result_d;

    logic           is_signed, sign_a, sign_b;
    logic [W-1:0]   mag_a, mag_b;
    logic           div_zero, ovf;
    logic [W+1:0]   rem_sh, trial;
    logic [W-1:0]   quo_nxt;
    logic [W:0]     rem_nxt;
    logic [W-1:0]   quo_res, rem_res;

    // Operand decode and one restoring-division step on the current registers
    always_comb begin
        is_signed = ~op[0];
        sign_a    = is_signed & A[W-1];
        sign_b    = is_signed & B[W-1];
        mag_a     = sign_a ? -A : A;
        mag_b     = sign_b ? -B : B;
        div_zero  = (B == '0);
        ovf       = is_signed && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

        rem_sh  = {rem_q, quo_q[W-1]};
        trial   = rem_sh - {2'b00, dvsr_q};
        quo_nxt = {quo_q[W-2:0], ~trial[W+1]};
        rem_nxt = trial[W+1] ? rem_sh[W:0] : trial[W:0];
        quo_res = neg_quo_q ? -quo_nxt : quo_nxt;
        rem_res = neg_rem_q ? -rem_nxt[W-1:0] : rem_nxt[W-1:0];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (div_zero || ovf) begin
                        // Special cases resolve at the accepting edge and skip CALC
                        state_d = DONE;
                        done_d  = 1'b1;
                        if (op[1]) result_d = div_zero ? A : '0;
                        else       result_d = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
                    end else begin
                        state_d   = CALC;
                        is_rem_d  = op[1];
                        neg_quo_d = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
                        quo_d     = mag_a;
                        dvsr_d    = mag_b;
                        rem_d     = '0;
                        cnt_d     = CW'(31);
                    end
                end
            end
            CALC: begin
                quo_d = quo_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = is_rem_q ? rem_res : quo_res;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus a random sweep
// compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V division semantics via 64-bit arithmetic (truncating / and %)
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit mid);
        logic [31:0] exp_res;
        int          exp_lat;
        int          lat;
        int          busy_bad;
        bit          seen;
        exp_res = model(o, a, b);
        exp_lat = is_special(o, a, b) ? 1 : 33;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
        lat = 0; busy_bad = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            lat++;
            if (!busy) busy_bad++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (mid && lat == 5) begin
                    start = 1'b1; op = ~o; A = $urandom; B = $urandom | 32'd1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_hold"}, result, exp_res);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        // Reset with start held high: start must be ignored
        reset = 1'b1; start = 1'b1; op = 2'b01; A = 32'd100; B = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);

        do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0);
        chk("divu_direct", result, 32'd14);
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
        chk("remu_direct", result, 32'd2);
        do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_direct", result, 32'hFFFF_FFFD);
        do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("rem_direct", result, 32'hFFFF_FFFF);
        do_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
        chk("rem_pos_direct", result, 32'd1);
        do_op("divu_by0", 2'b01, 32'd5, 32'd0, 1'b0);
        chk("divu_by0_direct", result, 32'hFFFF_FFFF);
        do_op("rem_by0", 2'b10, 32'h1234_5678, 32'd0, 1'b0);
        chk("rem_by0_direct", result, 32'h1234_5678);
        do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_direct", result, 32'h8000_0000);
        do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("rem_ovf_direct", result, 32'd0);
        do_op("mid_start", 2'b01, 32'd1000, 32'd9, 1'b1);
        chk("mid_start_direct", result, 32'd111);

        // Reset 10 cycles into CALC abandons the division
        @(negedge clk);
        start = 1'b1; op = 2'b01; A = 32'd1000; B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_nodone", {31'd0, done}, 32'd0);
        do_op("post_rst", 2'b00, 32'hFFFF_FF9C, 32'd7, 1'b0);
        chk("post_rst_direct", result, 32'hFFFF_FFF2);

        // Random sweep over all four ops with occasional corner operands
        for (int i = 0; i < 1000; i++) begin
            ro  = 2'($urandom);
            sel = $urandom_range(0, 15);
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            if (sel == 0) begin
                rb = 32'd0;
            end else if (sel == 1) begin
                ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                ra = 32'($urandom_range(0, 200));
                rb = 32'($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) ra = -ra;
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            do_op("rnd", ro, ra, rb, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divide unit implementing the RV32M DIV, DIVU, REM and REMU operations. It sits in the execute stage beside the combinational ALU. The ALU covers single-cycle add/sub/logic/shift/compare. This block handles division, which cannot close timing combinationally: one quotient bit per cycle, with a start/busy/done handshake that the pipeline control uses to stall.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled only in IDLE
- op  input  2  2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU (funct3[1:0])
- A  input  32  dividend; sampled with start
- B  input  32  divisor; sampled with start
- busy  output  1  high while an operation is in flight (CALC or DONE)
- done  output  1  one-cycle pulse; result valid that cycle
- result  output  32  quotient (DIV/DIVU) or remainder (REM/REMU)

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC: start=1 at a rising edge and not a special case. Latch op and sign flags. Load the magnitude of A into the quotient register, the magnitude of B into the divisor register, clear the 33-bit partial remainder, and load the iteration counter with 31.
- Magnitude rule: for DIV/REM, negate an operand if its bit 31 is set. For DIVU/REMU, use the raw value.
- CALC, per cycle (restoring division):
  - shift {rem, quo} left by one;
  - trial = rem_shifted - {1'b0, divisor};
  - if the trial is non-negative, set rem = trial and quo[0] = 1; otherwise keep the shifted rem and set quo[0] = 0;
  - decrement the counter. Leave for DONE after the iteration where the counter is 0, which gives exactly 32 iterations.
- DONE: drive result and done=1 for one cycle, then go to IDLE.
- Sign fix for signed ops:
  - quotient is negated if sign(A) XOR sign(B);
  - remainder is negated if sign(A).
- Special cases bypass CALC. IDLE goes directly to DONE, and result is computed at the start edge.
  - B == 0: DIV/DIVU give 32'hFFFF_FFFF; REM/REMU give A.
  - DIV/REM with A == 32'h8000_0000 and B == 32'hFFFF_FFFF: DIV gives 32'h8000_0000, REM gives 0.
- start is ignored in CALC and DONE. Operands changing after acceptance have no effect.
- result holds its last value until the next DONE. It is not cleared on return to IDLE.
- Reset values: state IDLE, busy 0, done 0, result 0, internal registers 0. Reset mid-operation abandons the division with no done pulse. start in the same cycle as reset is ignored.

## Timing
- Let E0 be the rising edge at which start is accepted.
- busy goes high after E0 and stays high through the DONE cycle. It is low in IDLE.
- Normal path:
  - CALC occupies the 32 cycles after E0;
  - done=1 in the cycle after edge E32, so latency from acceptance to done is 33 cycles;
  - busy is low after E33.
- Special-case path: done=1 in the cycle after E0, and busy is high for that one cycle.
- Back-to-back: the earliest next acceptance is at the edge where DONE exits to IDLE plus one, i.e. start must be seen while in IDLE. Throughput is one division per 34 cycles (normal) or 2 cycles (special).
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- DIVU A=100, B=7 -> done exactly 33 cycles after acceptance, result 14. REMU with the same operands -> 2.
- DIV A=-7 (32'hFFFF_FFF9), B=2 -> 32'hFFFF_FFFD (-3). REM with the same operands -> 32'hFFFF_FFFF (-1). REM A=7, B=-2 -> 1.
- Divide by zero:
  - DIVU A=5, B=0 -> 32'hFFFF_FFFF, done 1 cycle after acceptance;
  - REM A=32'h1234_5678, B=0 -> 32'h1234_5678.
- Overflow: DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000. REM with the same operands -> 0. Both complete in 1 cycle.
- start pulsed mid-CALC with different operands -> ignored; the original result is delivered on schedule and busy never drops early.
- reset asserted 10 cycles into CALC -> next cycle busy=0, done=0, result=0, state IDLE. A new start is then accepted and produces the correct result. Also run a 1000-operation random DIV/DIVU/REM/REMU sweep against a reference model.
